spidac_seq: RTL and testbench

SPIDAC_SEQ -- requirements
Module: spidac_seq

---
 rtl/spidac_seq.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_spidac_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spidac_seq.sv
// Multi-channel SPI DAC sweep sequencer: registers are snapshotted at start, 16-bit frames go out MSB first, then one common LDAC strobe.
// Reads have 1-clk latency; a start while busy is dropped (no queuing). SPIDAC_SEQ_STEP_EN adds a saturating code += STEP at each sweep end.
module spidac_seq #(
  parameter int N_CH     = 4,
  parameter int DAC_BITS = 12,
  parameter int CLK_DIV  = 2
) (
  input  logic            clk,
  input  logic            res,
  input  logic            we,
  input  logic [7:0]      addr,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  input  logic            start_step,
  output logic            SCK,
  output logic            SDI,
  output logic [N_CH-1:0] nCS,
  output logic            nLDAC,
  output logic            busy,
  output logic            done
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW  = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] C_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] L_END = CW'(2 * CLK_DIV - 1);
  localparam logic [11:0] CODE_MASK = 12'((1 << DAC_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_LDAC, S_DONE
  } state_t;

  // Register file
  logic [7:0]      r_lo [N_CH];
  logic [6:0]      r_hi [N_CH];
  logic [N_CH-1:0] r_mask;
  logic            r_sticky;
  logic [7:0]      r_dout;
  logic            r_step_d;
`ifdef SPIDAC_SEQ_STEP_EN
  logic [7:0]      r_step;
  logic [11:0]     w_stepped [N_CH];
`endif

  // Sequencer state and registered pin drivers
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_bit, w_bit_nxt;
  logic            r_ph, w_ph_nxt;
  logic [CHW-1:0]  r_ch, w_ch_nxt;
  logic [N_CH-1:0] r_sent, w_sent_nxt;
  logic [N_CH-1:0] r_snap_mask;
  logic [15:0]     r_frame [N_CH];
  logic            r_sck, w_sck_nxt;
  logic            r_sdi, w_sdi_nxt;
  logic [N_CH-1:0] r_ncs, w_ncs_nxt;
  logic            r_nldac, w_nldac_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;

  logic            w_clr, w_start;
  logic            w_pick_vld;
  logic [CHW-1:0]  w_pick;
  logic [N_CH-1:0] w_wr_lo, w_wr_hi;
  logic [11:0]     w_code [N_CH];
  logic [7:0]      w_rd;

  assign w_clr   = res | (we & (addr == 8'h00) & data_in[0]);
  assign w_start = ((we & (addr == 8'h00) & data_in[1]) | (start_step & ~r_step_d))
                   & (r_state == S_IDLE) & ~w_clr;

  always_comb begin
    w_wr_lo = '0;
    w_wr_hi = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_wr_lo[k] = we & (addr == 8'(16 + 2 * k));
      w_wr_hi[k] = we & (addr == 8'(17 + 2 * k));
      w_code[k]  = {r_hi[k][3:0], r_lo[k]} & CODE_MASK;
    end
  end

`ifdef SPIDAC_SEQ_STEP_EN
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      logic [12:0] sum;
      sum = {1'b0, w_code[k]} + 13'(r_step);
      w_stepped[k] = (sum > 13'(CODE_MASK)) ? CODE_MASK : sum[11:0];
    end
  end
`endif

  // Lowest-index enabled channel not yet sent in this sweep
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_snap_mask[k] && !r_sent[k]) begin
        w_pick_vld = 1'b1;
        w_pick     = CHW'(k);
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (addr)
      8'h01: w_rd = {6'd0, r_sticky, r_busy};
      8'h02: w_rd = 8'(r_mask);
`ifdef SPIDAC_SEQ_STEP_EN
      8'h03: w_rd = r_step;
`endif
      default: begin
        for (int k = 0; k < N_CH; k++) begin
          if (addr == 8'(16 + 2 * k))      w_rd = r_lo[k];
          else if (addr == 8'(17 + 2 * k)) w_rd = {1'b0, r_hi[k]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_step_d <= start_step;
    if (w_clr) begin
      r_mask   <= '0;
      r_sticky <= 1'b0;
      r_dout   <= '0;
`ifdef SPIDAC_SEQ_STEP_EN
      r_step   <= '0;
`endif
      for (int k = 0; k < N_CH; k++) begin
        r_lo[k] <= '0;
        r_hi[k] <= '0;
      end
    end else begin
      r_dout <= w_rd;
      if (we && addr == 8'h02) r_mask <= data_in[N_CH-1:0];
`ifdef SPIDAC_SEQ_STEP_EN
      if (we && addr == 8'h03) r_step <= data_in;
`endif
      // A completion in the same clk as a clear keeps the event visible
      if (r_state == S_DONE)              r_sticky <= 1'b1;
      else if (we && addr == 8'h01)       r_sticky <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if (w_wr_lo[k]) r_lo[k] <= data_in;
        if (w_wr_hi[k]) r_hi[k] <= data_in[6:0];
`ifdef SPIDAC_SEQ_STEP_EN
        if (!w_wr_lo[k] && !w_wr_hi[k] && r_state == S_DONE && r_snap_mask[k])
          {r_hi[k][3:0], r_lo[k]} <= w_stepped[k];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_snap_mask <= '0;
      for (int k = 0; k < N_CH; k++) r_frame[k] <= '0;
    end else if (w_start) begin
      r_snap_mask <= r_mask;
      for (int k = 0; k < N_CH; k++) r_frame[k] <= {1'b0, r_hi[k][6:4], w_code[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_ph    <= 1'b0;
      r_ch    <= '0;
      r_sent  <= '0;
      r_sck   <= 1'b0;
      r_sdi   <= 1'b0;
      r_ncs   <= '1;
      r_nldac <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_ph    <= w_ph_nxt;
      r_ch    <= w_ch_nxt;
      r_sent  <= w_sent_nxt;
      r_sck   <= w_sck_nxt;
      r_sdi   <= w_sdi_nxt;
      r_ncs   <= w_ncs_nxt;
      r_nldac <= w_nldac_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Pin values are computed for the state being entered so every output is a flop
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_ph_nxt    = r_ph;
    w_ch_nxt    = r_ch;
    w_sent_nxt  = r_sent;
    w_sck_nxt   = r_sck;
    w_sdi_nxt   = r_sdi;
    w_ncs_nxt   = r_ncs;
    w_nldac_nxt = r_nldac;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SELECT;
          w_cnt_nxt   = '0;
          w_sent_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SELECT: begin
        if (!w_pick_vld) begin
          w_cnt_nxt = '0;
          if (r_snap_mask == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_LDAC;
            w_nldac_nxt = 1'b0;
          end
        end else if (r_cnt == C_END) begin
          w_state_nxt       = S_CS_SETUP;
          w_cnt_nxt         = '0;
          w_ch_nxt          = w_pick;
          w_ncs_nxt         = '1;
          w_ncs_nxt[w_pick] = 1'b0;
          w_sdi_nxt         = r_frame[w_pick][15];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CS_SETUP: begin
        if (r_cnt == C_END) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd15;
          w_ph_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (r_cnt == C_END) begin
          w_cnt_nxt = '0;
          if (!r_ph) begin
            w_ph_nxt  = 1'b1;
            w_sck_nxt = 1'b1;
          end else if (r_bit == 4'd0) begin
            w_state_nxt      = S_CS_HOLD;
            w_ph_nxt         = 1'b0;
            w_sck_nxt        = 1'b0;
            w_sent_nxt[r_ch] = 1'b1;
          end else begin
            w_ph_nxt  = 1'b0;
            w_sck_nxt = 1'b0;
            w_bit_nxt = r_bit - 4'd1;
            w_sdi_nxt = r_frame[r_ch][r_bit - 4'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CS_HOLD: begin
        // Phase 0: SCK low with nCS held; phase 1: nCS released before next select
        if (r_cnt == C_END) begin
          w_cnt_nxt = '0;
          if (!r_ph) begin
            w_ph_nxt  = 1'b1;
            w_ncs_nxt = '1;
            w_sdi_nxt = 1'b0;
          end else begin
            w_ph_nxt    = 1'b0;
            w_state_nxt = S_SELECT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LDAC: begin
        if (r_cnt == L_END) begin
          w_cnt_nxt   = '0;
          w_nldac_nxt = 1'b1;
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign data_out = r_dout;
  assign SCK      = r_sck;
  assign SDI      = r_sdi;
  assign nCS      = r_ncs;
  assign nLDAC    = r_nldac;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_spidac_seq.sv
// Scoreboard bench for spidac_seq: expected frames are queued when a sweep is started and
// compared against words reassembled from SCK/SDI/nCS.
module tb_spidac_seq;
  localparam int N_CH     = 4;
  localparam int DAC_BITS = 12;
  localparam int CLK_DIV  = 2;

  logic            clk = 1'b0;
  logic            res, we, start_step;
  logic [7:0]      addr, data_in, data_out;
  logic            SCK, SDI, nLDAC, busy, done;
  logic [N_CH-1:0] nCS;

  always #5 clk = ~clk;

  spidac_seq #(.N_CH(N_CH), .DAC_BITS(DAC_BITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .res(res), .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
    .start_step(start_step), .SCK(SCK), .SDI(SDI), .nCS(nCS), .nLDAC(nLDAC),
    .busy(busy), .done(done)
  );

  typedef struct {
    int          ch;
    logic [15:0] word;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Register mirror
  logic [7:0]      m_lo [N_CH];
  logic [6:0]      m_hi [N_CH];
  logic [N_CH-1:0] m_mask;

  function automatic int sweep_len(input logic [N_CH-1:0] mask);
    int m;
    m = $countones(mask);
    return (m == 0) ? 2 : m * 36 * CLK_DIV + 2 * CLK_DIV + 2;
  endfunction

  task automatic mirror_clear();
    for (int k = 0; k < N_CH; k++) begin
      m_lo[k] = '0;
      m_hi[k] = '0;
    end
    m_mask = '0;
  endtask

  task automatic push_sweep();
    exp_t e;
    for (int k = 0; k < N_CH; k++) begin
      if (m_mask[k]) begin
        e.ch   = k;
        e.word = {1'b0, m_hi[k], m_lo[k]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_word(input int ch, input logic [15:0] w);
    exp_t e;
    e.ch   = ch;
    e.word = w;
    exp_q.push_back(e);
  endtask

  // Monitor
  logic            mon_en = 1'b0;
  logic            mon_ignore = 1'b0;
  logic [N_CH-1:0] prev_ncs = '1;
  logic            prev_sck = 1'b0, prev_sdi = 1'b0, prev_nldac = 1'b1;
  logic [15:0]     mon_sh = '0;
  int mon_nbits = 0, mon_ch = 0, mon_frames = 0, mon_busy = 0, mon_done = 0;
  int mon_ldac = 0, mon_ldac_err = 0, mon_overlap = 0, mon_sdi_err = 0, ldac_w = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) mon_busy++;
      if (done) mon_done++;
      if ($countones(~nCS) > 1) mon_overlap++;
      if (!nLDAC && nCS != '1) mon_ldac_err++;
      if (prev_ncs == '1 && nCS != '1) begin
        mon_nbits = 0;
        mon_sh    = '0;
        for (int k = 0; k < N_CH; k++) if (!nCS[k]) mon_ch = k;
        mon_frames++;
      end else if (nCS != '1 && prev_ncs != '1 && SDI != prev_sdi && !(prev_sck && !SCK)) begin
        mon_sdi_err++;
      end
      if (nCS != '1 && !prev_sck && SCK) begin
        mon_sh = {mon_sh[14:0], SDI};
        mon_nbits++;
      end
      if (prev_ncs != '1 && nCS == '1 && !mon_ignore) begin
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 32'(mon_sh), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_ch", 32'(mon_ch), 32'(e.ch));
          chk("frame_word", 32'(mon_sh), 32'(e.word));
          chk("frame_bits", 32'(mon_nbits), 32'd16);
        end
      end
      if (prev_nldac && !nLDAC) ldac_w = 1;
      else if (!nLDAC)          ldac_w++;
      if (!prev_nldac && nLDAC) begin
        mon_ldac++;
        if (ldac_w != 2 * CLK_DIV) mon_ldac_err++;
      end
      prev_ncs   = nCS;
      prev_sck   = SCK;
      prev_sdi   = SDI;
      prev_nldac = nLDAC;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1;
    addr = a;
    data_in = d;
    tick();
    we = 1'b0;
    if (a == 8'h00 && d[0]) mirror_clear();
    if (a == 8'h02) m_mask = d[N_CH-1:0];
    if (a >= 8'h10 && a < 8'(16 + 2 * N_CH)) begin
      if (a[0]) m_hi[(a - 8'h10) >> 1] = d[6:0];
      else      m_lo[(a - 8'h10) >> 1] = d;
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    addr = a;
    tick();
    v = data_out;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
  endtask

  task automatic sweep_cmd();
    push_sweep();
    wr(8'h00, 8'h02);
    wait_done(2000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int f0, l0, d0, b0;
    int n;
    res = 1'b1; we = 1'b0; addr = '0; data_in = '0; start_step = 1'b0;
    mirror_clear();
    repeat (3) tick();
    chk("rst_ncs", 32'(nCS), 32'hF);
    chk("rst_sck", 32'(SCK), 0);
    chk("rst_nldac", 32'(nLDAC), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dout", 32'(data_out), 0);
    res = 1'b0;
    mon_en = 1'b1;
    rd(8'h02, v);
    chk("rst_mask", 32'(v), 0);

    // Single channel 1, code 0x5A3, cfg 0x7
    wr(8'h12, 8'hA3);
    wr(8'h13, 8'h75);
    wr(8'h02, 8'h02);
    f0 = mon_frames; l0 = mon_ldac; d0 = mon_done; b0 = mon_busy;
    push_sweep();
    chk("t1_exp_word", 32'(exp_q[0].word), 32'h75A3);
    wr(8'h00, 8'h02);
    chk("t1_busy_next", 32'(busy), 1);
    wait_done(2000);
    chk("t1_frames", 32'(mon_frames - f0), 1);
    chk("t1_ldac", 32'(mon_ldac - l0), 1);
    chk("t1_done", 32'(mon_done - d0), 1);
    chk("t1_len", 32'(mon_busy - b0), 32'(sweep_len(4'h2)));
    rd(8'h01, v);
    chk("t1_status", 32'(v), 32'h02);
    wr(8'h01, 8'h00);
    rd(8'h01, v);
    chk("t1_status_clr", 32'(v), 0);
    rd(8'h13, v);
    chk("t1_rd_hi", 32'(v), 32'h75);

    // Channels 0, 1, 3 via start_step edge
    wr(8'h10, 8'h11); wr(8'h11, 8'h32);
    wr(8'h16, 8'hCD); wr(8'h17, 8'h4B);
    wr(8'h02, 8'h0B);
    f0 = mon_frames; l0 = mon_ldac; b0 = mon_busy;
    push_sweep();
    start_step = 1'b1;
    tick();
    start_step = 1'b0;
    wait_done(2000);
    chk("t2_frames", 32'(mon_frames - f0), 3);
    chk("t2_ldac", 32'(mon_ldac - l0), 1);
    chk("t2_len", 32'(mon_busy - b0), 32'(sweep_len(4'hB)));
    chk("t2_q_empty", 32'(exp_q.size()), 0);

    // Restart while busy is dropped; writes during a sweep do not touch the snapshot
    wr(8'h02, 8'h02);
    f0 = mon_frames; d0 = mon_done; b0 = mon_busy;
    push_sweep();
    wr(8'h00, 8'h02);
    repeat (10) tick();
    wr(8'h00, 8'h02);
    start_step = 1'b1;
    tick();
    start_step = 1'b0;
    wr(8'h12, 8'h11);
    wait_done(2000);
    repeat (100) tick();
    chk("t3_frames", 32'(mon_frames - f0), 1);
    chk("t3_done", 32'(mon_done - d0), 1);
    chk("t3_len", 32'(mon_busy - b0), 32'(sweep_len(4'h2)));
    sweep_cmd();
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    // Empty mask
    wr(8'h02, 8'h00);
    f0 = mon_frames; l0 = mon_ldac; b0 = mon_busy;
    wr(8'h00, 8'h02);
    tick();
    chk("t4_done_2clk", 32'(done), 1);
    repeat (5) tick();
    chk("t4_frames", 32'(mon_frames - f0), 0);
    chk("t4_ldac", 32'(mon_ldac - l0), 0);
    chk("t4_len", 32'(mon_busy - b0), 32'(sweep_len(4'h0)));

    // Reset in the middle of a frame
    wr(8'h02, 8'h02);
    f0 = mon_frames;
    push_sweep();
    wr(8'h00, 8'h02);
    n = 0;
    while (!(mon_frames > f0 && mon_nbits == 8 && SCK == 1'b0) && n < 1000) begin
      tick();
      n++;
    end
    chk("t5_reached_bit7", 32'(mon_nbits), 8);
    l0 = mon_ldac; d0 = mon_done;
    mon_ignore = 1'b1;
    res = 1'b1;
    tick();
    chk("t5_ncs", 32'(nCS), 32'hF);
    chk("t5_sck", 32'(SCK), 0);
    chk("t5_nldac", 32'(nLDAC), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    res = 1'b0;
    exp_q.delete();
    mirror_clear();
    repeat (100) tick();
    mon_ignore = 1'b0;
    chk("t5_no_done", 32'(mon_done - d0), 0);
    chk("t5_no_ldac", 32'(mon_ldac - l0), 0);
    rd(8'h13, v);
    chk("t5_reg_clr", 32'(v), 0);

    // Soft reset clears storage
    wr(8'h14, 8'h55);
    wr(8'h02, 8'h05);
    wr(8'h00, 8'h01);
    rd(8'h14, v);
    chk("t6_code_clr", 32'(v), 0);
    rd(8'h02, v);
    chk("t6_mask_clr", 32'(v), 0);

    // STEP register and auto-increment
    wr(8'h14, 8'hE0);
    wr(8'h15, 8'h0F);
    wr(8'h02, 8'h04);
    wr(8'h03, 8'h40);
    rd(8'h03, v);
`ifdef SPIDAC_SEQ_STEP_EN
    chk("t7_step_rd", 32'(v), 32'h40);
    push_word(2, 16'h0FE0); wr(8'h00, 8'h02); wait_done(2000);
    push_word(2, 16'h0FFF); wr(8'h00, 8'h02); wait_done(2000);
    push_word(2, 16'h0FFF); wr(8'h00, 8'h02); wait_done(2000);
    rd(8'h14, v);
    chk("t7_code_lo", 32'(v), 32'hFF);
    rd(8'h15, v);
    chk("t7_code_hi", 32'(v), 32'h0F);
`else
    chk("t7_step_rd", 32'(v), 0);
    push_word(2, 16'h0FE0); wr(8'h00, 8'h02); wait_done(2000);
    push_word(2, 16'h0FE0); wr(8'h00, 8'h02); wait_done(2000);
    rd(8'h14, v);
    chk("t7_code_lo", 32'(v), 32'hE0);
`endif

    repeat (5) tick();
    chk("q_empty", 32'(exp_q.size()), 0);
    chk("ncs_overlap", 32'(mon_overlap), 0);
    chk("sdi_edges", 32'(mon_sdi_err), 0);
    chk("ldac_rules", 32'(mon_ldac_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
